pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and stall controller for the 5-stage RV32 pipeline. It watches the instruction in the IF/ID register, the instruction in EX, the EX branch outcome, the multi-cycle (mul/div) unit and the instruction-memory ready line. From these it drives the PC write enable, the IF/ID hold (`stage1_rewrite`) and flush controls, the ID/EX bubble and the EX freeze. It also keeps saturating stall and flush performance counters and a sticky multi-cycle timeout flag.

## Interface
Parameters:
- `MC_TIMEOUT`, default 64: maximum number of MC_WAIT cycles before the controller aborts the wait.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `id_rs1`, `id_rs2`  in  5 each: source registers of the instruction in IF/ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each: the instruction in IF/ID reads that source.
- `ex_rd`  in  5: destination register of the instruction in EX.
- `ex_mem_read`  in  1: the instruction in EX is a load.
- `ex_branch_taken`  in  1: the instruction in EX redirects the PC (taken branch, jal or jalr).
- `ex_mc_start`  in  1: a multi-cycle operation is in EX.
- `mc_done`  in  1: the multi-cycle result is valid.
- `imem_ready`  in  1: the fetch data for the current PC is valid.
- `pc_write`  out  1: PC register load enable.
- `stage1_rewrite`  out  1: hold the IF/ID register.
- `flush_if_id`  out  1: load a bubble into IF/ID.
- `bubble_id_ex`  out  1: load a bubble into ID/EX.
- `hold_ex`  out  1: freeze the ID/EX register and the EX operands.
- `mc_timeout`  out  1: sticky error flag.
- `stall_cnt`  out  CNT_W: count of cycles with `pc_write`=0 outside reset; saturating.
- `flush_cnt`  out  CNT_W: count of cycles with `flush_if_id`=1 caused by a redirect; saturating.

## Operation
- Two-state FSM:
  - RUN: default state.
  - MC_WAIT: multi-cycle operation in progress.
- Control outputs are Mealy, decoded from the state and the current-cycle inputs.
- The counters and `mc_timeout` are registered.
- Load-use hazard: `ex_mem_read` && `ex_rd`≠0 && ((`id_use_rs1` && `id_rs1`==`ex_rd`) || (`id_use_rs2` && `id_rs2`==`ex_rd`)).
- RUN priority, highest first:
  1. `ex_branch_taken`: `pc_write`=1, `flush_if_id`=1, `bubble_id_ex`=1. `flush_cnt` increments.
  2. `ex_mc_start`: `pc_write`=0, `stage1_rewrite`=1, `hold_ex`=1. Next state MC_WAIT.
  3. Load-use hazard: `pc_write`=0, `stage1_rewrite`=1, `bubble_id_ex`=1 for this cycle only.
  4. `!imem_ready`: `pc_write`=0, `flush_if_id`=1.
  5. Otherwise: `pc_write`=1 and all other control outputs 0.
- MC_WAIT behaviour:
  - Drives `pc_write`=0, `stage1_rewrite`=1, `hold_ex`=1.
  - `ex_branch_taken`, the load-use hazard and `imem_ready` are ignored, because EX is frozen.
  - Wait counter `wcnt` (width `$clog2(MC_TIMEOUT+1)`) is cleared on entry and increments each cycle.
  - `mc_done`=1: the outputs still hold this cycle; next state RUN.
  - `wcnt`==MC_TIMEOUT-1 without `mc_done`: set `mc_timeout`; next state RUN (abort).
- `stage1_rewrite` and `flush_if_id` are never both 1.
- `pc_write`=1 never coincides with `stage1_rewrite`=1.
- Counters saturate at all-ones. Only reset clears them. `mc_timeout` is cleared only by reset.

## Timing
- While `rst_n`=0 at a clock edge, the block is in reset:
  - Next-cycle values: state RUN, `wcnt`=0, `stall_cnt`=0, `flush_cnt`=0, `mc_timeout`=0.
  - Combinational outputs are forced while `rst_n`=0: `pc_write`=0, `stage1_rewrite`=0, `flush_if_id`=1, `bubble_id_ex`=1, `hold_ex`=0.
- Zero-cycle latency from inputs to control outputs; the state updates on the next edge.
- A load-use stall lasts exactly 1 cycle, because the load leaves EX.
- A multi-cycle stall lasts N+1 cycles when `mc_done` arrives N cycles after entering MC_WAIT.
- `ex_mc_start` together with `ex_branch_taken` in RUN: the branch wins; the operation is not waited on.
- Reset in MC_WAIT: return to RUN immediately. The counters clear and the wait is lost.

## Structure
- Package `hazard_pkg`: localparams `ST_RUN`=1'b0 and `ST_MC_WAIT`=1'b1, plus the x0 register index constant.
- One sub-module, `sat_counter` (parameter W; inputs `clk`, `rst_n`, `inc`; output `count`), instantiated for `stall_cnt` and for `flush_cnt`.
- Top level: hazard comparator, priority decoder, FSM with `wcnt`, and the timeout flag.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 → for one cycle `pc_write`=0, `stage1_rewrite`=1, `bubble_id_ex`=1; `stall_cnt` 0→1. The same stimulus with `ex_rd`=0 produces no stall.
- Branch: `ex_branch_taken`=1 together with a load-use hazard → `pc_write`=1, `flush_if_id`=1, `bubble_id_ex`=1, `stage1_rewrite`=0; `flush_cnt`=1.
- Multi-cycle: pulse `ex_mc_start`, assert `mc_done` 3 cycles after MC_WAIT entry → 4 stall cycles with `hold_ex`=1, then RUN; `stall_cnt`=4.
- Timeout: MC_TIMEOUT=8 and `mc_done` never asserted → return to RUN after 8 MC_WAIT cycles; `mc_timeout`=1 and it stays set.
- Fetch wait: `imem_ready`=0 for 2 cycles → `pc_write`=0 and `flush_if_id`=1 for both cycles.
- Reset mid-MC_WAIT: drop `rst_n` at cycle 2 → state RUN, counters 0, `flush_if_id`=1 and `bubble_id_ex`=1 during reset. Also: CNT_W=2 with 5 stalls → `stall_cnt` saturates at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ST_RUN / ST_MC_WAIT : controller state encoding
//   REG_X0              : index of the hardwired-zero register
//   load_use_hazard()   : true when the ID instruction needs a load result still in EX
package hazard_pkg;

    localparam int unsigned REG_IDX_W = 5;

    localparam logic ST_RUN     = 1'b0;
    localparam logic ST_MC_WAIT = 1'b1;

    localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

    // A load targeting x0 never produces a value, so it cannot cause a hazard.
    function automatic logic load_use_hazard(
        input logic                 mem_read,
        input logic [REG_IDX_W-1:0] rd,
        input logic [REG_IDX_W-1:0] rs1,
        input logic                 use_rs1,
        input logic [REG_IDX_W-1:0] rs2,
        input logic                 use_rs2
    );
        return mem_read && (rd != REG_X0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall / flush performance counters.
//   clk, rst_n : clock and synchronous active-low reset
//   inc        : count this cycle
//   count      : current value, sticks at all-ones
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32 pipeline.
// Decodes PC write / IF-ID hold and flush / ID-EX bubble / EX freeze from the
// current pipeline state, waits out multi-cycle operations with a timeout,
// and keeps saturating stall and redirect-flush counters.
//   inputs : id_rs1/id_rs2/id_use_rs1/id_use_rs2 (IF/ID sources), ex_rd,
//            ex_mem_read, ex_branch_taken, ex_mc_start (EX info), mc_done,
//            imem_ready
//   outputs: pc_write, stage1_rewrite, flush_if_id, bubble_id_ex, hold_ex
//            (combinational), mc_timeout, stall_cnt, flush_cnt (registered)
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_branch_taken,
    input  logic                 ex_mc_start,
    input  logic                 mc_done,
    input  logic                 imem_ready,
    output logic                 pc_write,
    output logic                 stage1_rewrite,
    output logic                 flush_if_id,
    output logic                 bubble_id_ex,
    output logic                 hold_ex,
    output logic                 mc_timeout,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int unsigned WCNT_W = $clog2(MC_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MC_TIMEOUT - 1);

    logic              r_state;
    logic              w_state_nxt;
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt_nxt;
    logic              r_mc_timeout;
    logic              w_timeout_set;
    logic              w_redirect;
    logic              w_hazard;

    assign w_hazard = load_use_hazard(ex_mem_read, ex_rd, id_rs1, id_use_rs1,
                                      id_rs2, id_use_rs2);

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_wcnt       <= '0;
            r_mc_timeout <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wcnt       <= w_wcnt_nxt;
            r_mc_timeout <= r_mc_timeout | w_timeout_set;
        end
    end

    // Priority decoder and next-state logic.
    always_comb begin
        pc_write       = 1'b1;
        stage1_rewrite = 1'b0;
        flush_if_id    = 1'b0;
        bubble_id_ex   = 1'b0;
        hold_ex        = 1'b0;
        w_state_nxt    = r_state;
        w_wcnt_nxt     = r_wcnt;
        w_timeout_set  = 1'b0;
        w_redirect     = 1'b0;

        if (!rst_n) begin
            // Keep bubbles flowing into the pipe while reset is held.
            pc_write     = 1'b0;
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
            w_state_nxt  = ST_RUN;
            w_wcnt_nxt   = '0;
        end else if (r_state == ST_RUN) begin
            if (ex_branch_taken) begin
                // Redirect wins over everything, including a pending mul/div.
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
                w_redirect   = 1'b1;
            end else if (ex_mc_start) begin
                pc_write       = 1'b0;
                stage1_rewrite = 1'b1;
                hold_ex        = 1'b1;
                w_state_nxt    = ST_MC_WAIT;
                w_wcnt_nxt     = '0;
            end else if (w_hazard) begin
                pc_write       = 1'b0;
                stage1_rewrite = 1'b1;
                bubble_id_ex   = 1'b1;
            end else if (!imem_ready) begin
                pc_write    = 1'b0;
                flush_if_id = 1'b1;
            end
        end else begin
            // EX is frozen, so redirects, hazards and fetch status are moot.
            pc_write       = 1'b0;
            stage1_rewrite = 1'b1;
            hold_ex        = 1'b1;
            w_wcnt_nxt     = r_wcnt + WCNT_W'(1);
            if (mc_done) begin
                w_state_nxt = ST_RUN;
            end else if (r_wcnt == WCNT_LAST) begin
                w_state_nxt   = ST_RUN;
                w_timeout_set = 1'b1;
            end
        end
    end

    assign mc_timeout = r_mc_timeout;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rst_n && !pc_write),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_redirect),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations followed by randomized traffic, all cross-checked every cycle
// against a behavioural model. A second instance with 2-bit counters covers
// saturation.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TMO   = 8;
    localparam int          MAX16 = 65535;
    localparam int          MAX2  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic       ex_mc_start, mc_done, imem_ready;

    logic        pc_write, stage1_rewrite, flush_if_id, bubble_id_ex, hold_ex, mc_timeout;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_write, s_stage1_rewrite, s_flush_if_id, s_bubble_id_ex, s_hold_ex, s_mc_timeout;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    bit m_waiting   = 1'b0;
    int m_wait_cyc  = 0;
    bit m_timeout   = 1'b0;
    int m_stalls    = 0;
    int m_flushes   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MC_TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_mc_start(ex_mc_start), .mc_done(mc_done), .imem_ready(imem_ready),
        .pc_write(pc_write), .stage1_rewrite(stage1_rewrite), .flush_if_id(flush_if_id),
        .bubble_id_ex(bubble_id_ex), .hold_ex(hold_ex), .mc_timeout(mc_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.MC_TIMEOUT(TMO), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_mc_start(ex_mc_start), .mc_done(mc_done), .imem_ready(imem_ready),
        .pc_write(s_pc_write), .stage1_rewrite(s_stage1_rewrite), .flush_if_id(s_flush_if_id),
        .bubble_id_ex(s_bubble_id_ex), .hold_ex(s_hold_ex), .mc_timeout(s_mc_timeout),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Compare process: predict outputs from the rules, check both instances, advance the model.
    always begin
        bit e_pc, e_rw, e_fl, e_bub, e_hold, hz;
        bit n_wait, n_tmo;
        int n_wcyc, n_st, n_fls;
        @(negedge clk);
        #2;
        if (chk_en) begin
            hz = ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
            e_pc = 1; e_rw = 0; e_fl = 0; e_bub = 0; e_hold = 0;
            n_wait = m_waiting; n_wcyc = m_wait_cyc; n_tmo = m_timeout;
            n_st = m_stalls; n_fls = m_flushes;
            if (!rst_n) begin
                e_pc = 0; e_fl = 1; e_bub = 1;
                n_wait = 0; n_wcyc = 0; n_tmo = 0; n_st = 0; n_fls = 0;
            end else if (m_waiting) begin
                e_pc = 0; e_rw = 1; e_hold = 1;
                if (mc_done) n_wait = 0;
                else if (m_wait_cyc + 1 == int'(TMO)) begin n_wait = 0; n_tmo = 1; end
                else n_wcyc = m_wait_cyc + 1;
            end else if (ex_branch_taken) begin
                e_fl = 1; e_bub = 1; n_fls = m_flushes + 1;
            end else if (ex_mc_start) begin
                e_pc = 0; e_rw = 1; e_hold = 1; n_wait = 1; n_wcyc = 0;
            end else if (hz) begin
                e_pc = 0; e_rw = 1; e_bub = 1;
            end else if (!imem_ready) begin
                e_pc = 0; e_fl = 1;
            end
            if (rst_n && !e_pc) n_st = m_stalls + 1;

            chk("pc_write",       32'(pc_write),       32'(e_pc));
            chk("stage1_rewrite", 32'(stage1_rewrite), 32'(e_rw));
            chk("flush_if_id",    32'(flush_if_id),    32'(e_fl));
            chk("bubble_id_ex",   32'(bubble_id_ex),   32'(e_bub));
            chk("hold_ex",        32'(hold_ex),        32'(e_hold));
            chk("mc_timeout",     32'(mc_timeout),     32'(m_timeout));
            chk("stall_cnt",      32'(stall_cnt),      32'(sat(m_stalls, MAX16)));
            chk("flush_cnt",      32'(flush_cnt),      32'(sat(m_flushes, MAX16)));
            chk("s_ctrl", 32'({s_pc_write, s_stage1_rewrite, s_flush_if_id, s_bubble_id_ex, s_hold_ex}),
                32'({e_pc, e_rw, e_fl, e_bub, e_hold}));
            chk("s_mc_timeout",   32'(s_mc_timeout),   32'(m_timeout));
            chk("s_stall_cnt",    32'(s_stall_cnt),    32'(sat(m_stalls, MAX2)));
            chk("s_flush_cnt",    32'(s_flush_cnt),    32'(sat(m_flushes, MAX2)));
            chk("rewrite_and_flush", 32'(stage1_rewrite && flush_if_id), 32'(0));
            chk("pc_and_rewrite",    32'(pc_write && stage1_rewrite),    32'(0));
        end
        @(posedge clk);
        if (chk_en) begin
            m_waiting = n_wait; m_wait_cyc = n_wcyc; m_timeout = n_tmo;
            m_stalls = n_st; m_flushes = n_fls;
        end
    end

    task automatic idle();
        rst_n = 1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_mem_read = 0; ex_branch_taken = 0; ex_mc_start = 0;
        mc_done = 0; imem_ready = 1;
    endtask

    // Advance to the next cycle's input-drive point.
    task automatic next_cycle();
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        @(negedge clk);
        rst_n = 0;
        chk_en = 1'b1;
        #3;
        chk("rst_pc_write", 32'(pc_write), 32'(0));
        chk("rst_flush", 32'({flush_if_id, bubble_id_ex, stage1_rewrite, hold_ex}), 32'(4'b1100));
        chk("rst_stall_cnt", 32'(stall_cnt), 32'(0));

        // Load-use stall for exactly one cycle
        next_cycle();
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        #3;
        chk("lu_ctrl", 32'({pc_write, stage1_rewrite, bubble_id_ex}), 32'(3'b011));
        next_cycle();
        #3;
        chk("lu_release", 32'(pc_write), 32'(1));
        chk("lu_stall_cnt", 32'(stall_cnt), 32'(1));

        // Load into x0 never stalls
        next_cycle();
        ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
        #3;
        chk("x0_no_stall", 32'({pc_write, stage1_rewrite}), 32'(2'b10));
        next_cycle();
        #3;
        chk("x0_stall_cnt", 32'(stall_cnt), 32'(1));

        // Branch overrides a concurrent load-use hazard
        next_cycle();
        ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        #3;
        chk("br_ctrl", 32'({pc_write, flush_if_id, bubble_id_ex, stage1_rewrite}), 32'(4'b1110));
        next_cycle();
        #3;
        chk("br_flush_cnt", 32'(flush_cnt), 32'(1));

        // Multi-cycle: done in the third wait cycle -> four stall cycles
        next_cycle();
        ex_mc_start = 1;
        #3;
        chk("mc_start_hold", 32'({pc_write, stage1_rewrite, hold_ex}), 32'(3'b011));
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            mc_done = (i == 2);
            ex_branch_taken = 1;
            #3;
            chk("mc_wait_hold", 32'({pc_write, hold_ex, flush_if_id}), 32'(3'b010));
        end
        next_cycle();
        #3;
        chk("mc_released", 32'({pc_write, hold_ex}), 32'(2'b10));
        chk("mc_stall_cnt", 32'(stall_cnt), 32'(5));
        chk("sat_stall_cnt", 32'(s_stall_cnt), 32'(3));

        // Fetch wait for two cycles
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            imem_ready = 0;
            #3;
            chk("fetch_wait", 32'({pc_write, flush_if_id}), 32'(2'b01));
        end
        next_cycle();
        #3;
        chk("fetch_stall_cnt", 32'(stall_cnt), 32'(7));

        // Timeout after TMO wait cycles, flag stays set
        next_cycle();
        ex_mc_start = 1;
        for (int i = 0; i < int'(TMO); i++) begin
            next_cycle();
            #3;
            chk("tmo_hold", 32'(hold_ex), 32'(1));
        end
        next_cycle();
        #3;
        chk("tmo_back_to_run", 32'({pc_write, hold_ex}), 32'(2'b10));
        chk("tmo_flag", 32'(mc_timeout), 32'(1));
        next_cycle();
        next_cycle();
        #3;
        chk("tmo_sticky", 32'(mc_timeout), 32'(1));
        chk("tmo_stall_cnt", 32'(stall_cnt), 32'(16));

        // Reset in the middle of a multi-cycle wait
        next_cycle();
        ex_mc_start = 1;
        next_cycle();
        next_cycle();
        rst_n = 0;
        #3;
        chk("rst_mid_wait", 32'({pc_write, stage1_rewrite, flush_if_id, bubble_id_ex, hold_ex}),
            32'(5'b00110));
        next_cycle();
        #3;
        chk("rst_mid_run", 32'({pc_write, hold_ex}), 32'(2'b10));
        chk("rst_mid_cnts", 32'({stall_cnt, flush_cnt}), 32'(0));
        chk("rst_mid_tmo", 32'(mc_timeout), 32'(0));

        // Randomized traffic, cross-checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            rst_n           = ($urandom_range(199) != 0);
            id_rs1          = 5'($urandom_range(3));
            id_rs2          = 5'($urandom_range(3));
            ex_rd           = 5'($urandom_range(3));
            id_use_rs1      = 1'($urandom_range(1));
            id_use_rs2      = 1'($urandom_range(1));
            ex_mem_read     = ($urandom_range(2) == 0);
            ex_branch_taken = ($urandom_range(7) == 0);
            ex_mc_start     = ($urandom_range(9) == 0);
            mc_done         = ($urandom_range(5) == 0);
            imem_ready      = ($urandom_range(4) != 0);
        end
        next_cycle();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
